// File: rtl/xt_bus_pkg.sv
// Shared types and default slave decode table for the XT bus controller.
package xt_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_HOLD
  } state_e;

  localparam int unsigned DEF_NUM_SLAVES = 8;
  localparam int unsigned DEF_ADDR_W     = 20;
  localparam int unsigned DEF_DATA_W     = 8;
  localparam int unsigned DEF_MAX_WAIT   = 7;

  // Slave 7 .. slave 0; slave 5 overlaps slaves 3/4 in I/O space, slave 6 asks for more waits than supported.
  localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_SLV_BASE = {
    20'h00300, 20'hF0000, 20'h00000, 20'h00060,
    20'h00040, 20'h80000, 20'h40000, 20'h00000
  };
  localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_SLV_MASK = {
    20'hFFF00, 20'hF0000, 20'hFFF80, 20'hFFFF0,
    20'hFFFF0, 20'hF0000, 20'hC0000, 20'hC0000
  };
  localparam logic [DEF_NUM_SLAVES-1:0]   DEF_SLV_IO   = 8'b1011_1000;
  localparam logic [DEF_NUM_SLAVES*4-1:0] DEF_SLV_WAIT = {
    4'd0, 4'd9, 4'd2, 4'd1, 4'd3, 4'd0, 4'd2, 4'd1
  };

  function automatic int unsigned cnt_w(input int unsigned max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CNT_W = cnt_w(DEF_MAX_WAIT);

endpackage

// File: rtl/xt_bus_ctrl_if.sv
// CPU-side strobes and slave-side channel signals of the XT bus controller.
interface xt_bus_if #(
  parameter int unsigned NUM_SLAVES = 8,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 8
) ();
  logic [ADDR_W-1:0]            addr;
  logic                         iom;
  logic                         rd_n;
  logic                         wr_n;
  logic                         inta_n;
  logic [DATA_W-1:0]            cpu_dout;
  logic [DATA_W-1:0]            cpu_din;
  logic                         ready;
  logic [NUM_SLAVES-1:0]        slv_sel;
  logic                         slv_rd;
  logic                         slv_wr;
  logic [DATA_W-1:0]            slv_wdata;
  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata;
  logic [DATA_W-1:0]            ivect;
  logic                         bus_err;

  modport master (
    output addr, iom, rd_n, wr_n, inta_n, cpu_dout, slv_rdata, ivect,
    input  cpu_din, ready, slv_sel, slv_rd, slv_wr, slv_wdata, bus_err
  );

  modport slave (
    input  addr, iom, rd_n, wr_n, inta_n, cpu_dout, slv_rdata, ivect,
    output cpu_din, ready, slv_sel, slv_rd, slv_wr, slv_wdata, bus_err
  );
endinterface

// File: rtl/xt_addr_decoder.sv
// Combinational priority decoder: lowest-indexed slave whose masked base and space match wins.
module xt_addr_decoder
  import xt_bus_pkg::*;
#(
  parameter int unsigned                       NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int unsigned                       ADDR_W     = DEF_ADDR_W,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]      SLV_BASE   = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]      SLV_MASK   = DEF_SLV_MASK,
  parameter logic [NUM_SLAVES-1:0]             SLV_IO     = DEF_SLV_IO,
  localparam int unsigned                      IDX_W      = idx_w(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              iom_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o
);

  always_comb begin
    logic found;
    found = 1'b0;
    idx_o = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!found && (SLV_IO[i] == iom_i) &&
          ((addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])) begin
        found = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
    hit_o = found;
  end

endmodule

// File: rtl/xt_bus_ctrl.sv
// XT bus controller: decodes CPU strobes into one-hot slave accesses with table-driven wait states.
module xt_bus_ctrl
  import xt_bus_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES = DEF_NUM_SLAVES,
  parameter int unsigned                  ADDR_W     = DEF_ADDR_W,
  parameter int unsigned                  DATA_W     = DEF_DATA_W,
  parameter int unsigned                  MAX_WAIT   = DEF_MAX_WAIT,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = DEF_SLV_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK   = DEF_SLV_MASK,
  parameter logic [NUM_SLAVES-1:0]        SLV_IO     = DEF_SLV_IO,
  parameter logic [NUM_SLAVES*4-1:0]      SLV_WAIT   = DEF_SLV_WAIT
) (
  input logic   clk_cpu,
  input logic   reset,
  xt_bus_if.slave bus
);

  localparam int unsigned IDX_W = idx_w(NUM_SLAVES);
  localparam int unsigned CW    = cnt_w(MAX_WAIT);

  state_e            state_q, state_d;
  logic              active_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     wait_q, wait_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              hit_q, hit_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic              dec_hit;
  logic [IDX_W-1:0]  dec_idx;
  logic [3:0]        wait_raw;
  logic [CW-1:0]     wait_clip;
  logic              act;
  logic              start;
  logic [DATA_W-1:0] cap_val;

  logic                  ready;
  logic [NUM_SLAVES-1:0] sel;
  logic                  srd;
  logic                  swr;
  logic                  berr;

  xt_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK),
    .SLV_IO     (SLV_IO)
  ) u_dec (
    .addr_i (bus.addr),
    .iom_i  (bus.iom),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  assign act      = ~bus.rd_n | ~bus.wr_n;
  // Interrupt acknowledge swallows a coincident start; active_q still records it so it never fires late.
  assign start    = act & ~active_q & bus.inta_n;
  assign wait_raw = SLV_WAIT[dec_idx*4 +: 4];
  assign wait_clip = (32'(wait_raw) > MAX_WAIT) ? CW'(MAX_WAIT) : CW'(wait_raw);
  assign cap_val  = hit_q ? bus.slv_rdata[idx_q*DATA_W +: DATA_W] : '1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    wr_d    = wr_q;
    err_d   = err_q;
    dout_d  = dout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCESS;
          idx_d   = dec_idx;
          hit_d   = dec_hit;
          wr_d    = ~bus.wr_n;
          err_d   = ~dec_hit | (~bus.rd_n & ~bus.wr_n);
          wait_d  = dec_hit ? wait_clip : '0;
        end
      end
      ST_ACCESS: begin
        if (wait_q == '0) begin
          dout_d  = cap_val;
          state_d = ST_HOLD;
        end else begin
          cnt_d   = wait_q;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CW'(1)) begin
          dout_d  = cap_val;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (bus.rd_n && bus.wr_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b1;
    sel   = '0;
    srd   = 1'b0;
    swr   = 1'b0;
    berr  = err_q && (state_q == ST_ACCESS);
    if ((state_q == ST_ACCESS) || (state_q == ST_WAIT)) begin
      ready = 1'b0;
      if (hit_q) begin
        sel[idx_q] = 1'b1;
        srd        = ~wr_q;
        swr        = wr_q && (state_q == ST_ACCESS);
      end
    end
    if (!bus.inta_n) begin
      ready = 1'b1;
      sel   = '0;
      srd   = 1'b0;
      swr   = 1'b0;
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      active_q <= 1'b1;
      cnt_q    <= '0;
      wait_q   <= '0;
      idx_q    <= '0;
      hit_q    <= 1'b0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      dout_q   <= '1;
    end else begin
      state_q  <= state_d;
      active_q <= act;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      idx_q    <= idx_d;
      hit_q    <= hit_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      dout_q   <= dout_d;
    end
  end

  assign bus.cpu_din   = bus.inta_n ? dout_q : bus.ivect;
  assign bus.ready     = ready;
  assign bus.slv_sel   = sel;
  assign bus.slv_rd    = srd;
  assign bus.slv_wr    = swr;
  assign bus.bus_err   = berr;
  assign bus.slv_wdata = bus.cpu_dout;

endmodule

// File: doc/xt_bus_ctrl.md
XT_BUS_CTRL -- requirements
Module: xt_bus_ctrl

Interface
REQ-001 SHALL provide parameter NUM_SLAVES, 8, number of decoded slave channels (1..16).
REQ-002 SHALL provide parameter ADDR_W, 20, CPU address width.
REQ-003 SHALL provide parameter DATA_W, 8, data width.
REQ-004 SHALL provide parameter MAX_WAIT, 7, largest wait-state count supported.
REQ-005 SHALL provide parameters SLV_BASE, SLV_MASK (NUM_SLAVES*ADDR_W each), SLV_IO (NUM_SLAVES, 1=I/O space) and SLV_WAIT (NUM_SLAVES*4), the per-slave decode and wait table.
REQ-006 SHALL use one clock and a synchronous, active-high reset: clk_cpu in 1 (sole clock, all logic on rising edge); reset in 1 (synchronous, active-high).
REQ-007 addr  in  ADDR_W  CPU address.
REQ-008 iom  in  1  1=I/O cycle, 0=memory cycle.
REQ-009 rd_n, wr_n, inta_n  in  1 each  active-low CPU strobes.
REQ-010 cpu_dout  in  DATA_W  CPU write data, forwarded unchanged on slv_wdata.
REQ-011 cpu_din  out  DATA_W  read data to CPU.
REQ-012 ready  out  1  CPU READY; low inserts wait states.
REQ-013 slv_sel  out  NUM_SLAVES  one-hot slave select; slv_rd, slv_wr  out  1 each  access strobes.
REQ-014 slv_rdata  in  NUM_SLAVES*DATA_W  packed slave read data; ivect  in  DATA_W  interrupt vector.
REQ-015 bus_err  out  1  one-cycle pulse on an unmapped or illegal access.

Function
REQ-016 Cycle start SHALL be the rising edge of registered active = ~rd_n | ~wr_n.
REQ-017 Decode SHALL select the lowest index i with (addr & SLV_MASK[i]) == SLV_BASE[i] and SLV_IO[i] == iom.
REQ-018 Decode SHALL latch the index, the direction and wait = min(SLV_WAIT[i], MAX_WAIT) at cycle start.
REQ-019 The FSM SHALL have states IDLE, ACCESS, WAIT and HOLD.
REQ-020 IDLE SHALL go to ACCESS on cycle start.
REQ-021 In ACCESS, if wait == 0 the block SHALL capture read data and go to HOLD; otherwise it SHALL load the counter and go to WAIT.
REQ-022 In WAIT the counter SHALL decrement each cycle; at 1 the block SHALL capture read data and go to HOLD.
REQ-023 HOLD SHALL go to IDLE once rd_n and wr_n are both high.
REQ-024 ready SHALL be 0 in ACCESS and WAIT and 1 in IDLE and HOLD, so a read has 1+wait cycles with ready low.
REQ-025 slv_sel[i] and slv_rd SHALL be asserted throughout ACCESS and WAIT.
REQ-026 slv_wr SHALL be asserted in ACCESS only (single-cycle write strobe).
REQ-027 cpu_din SHALL hold the captured slv_rdata[i] from capture until the next capture.
REQ-028 On an unmapped access the block SHALL assert no slv_sel, capture all-ones and pulse bus_err in ACCESS.
REQ-029 If rd_n and wr_n are low together, the cycle SHALL be a write and bus_err SHALL pulse.
REQ-030 While inta_n is low, cpu_din SHALL equal ivect combinationally, ready SHALL be 1 and no slave SHALL be selected.
REQ-031 INTA SHALL take precedence over a simultaneous cycle start, which is ignored.
REQ-032 If the strobes are released during WAIT, the block SHALL complete the count and then return to IDLE via HOLD.

Reset
REQ-033 Reset SHALL force state IDLE, counter 0, slv_sel 0, slv_rd 0, slv_wr 0, bus_err 0, ready 1 and cpu_din all-ones.
REQ-034 Reset SHALL set the registered active flag to 1, so a strobe held across reset starts no cycle until it is released and reasserted.
REQ-035 Reset asserted mid-cycle SHALL abort the cycle within one clock with no further slave strobes.

Structure
REQ-036 Package xt_bus_pkg SHALL hold the FSM state enum, default table constants and the counter width $clog2(MAX_WAIT+1).
REQ-037 Sub-module xt_addr_decoder SHALL implement the purely combinational priority match, producing hit and index outputs.

Verification
REQ-038 The bench SHALL cover: memory read, slave 2 with wait 0, slv_rdata = 8'hA5 -> ready low 1 cycle, cpu_din = 8'hA5 in HOLD.
REQ-039 The bench SHALL cover: I/O read at 0x0040, slave with wait 3 -> ready low exactly 4 cycles, slv_sel one-hot for 4 cycles.
REQ-040 The bench SHALL cover: write to unmapped 0xE0000 -> no slv_sel, bus_err high 1 cycle, cpu_din = 8'hFF.
REQ-041 The bench SHALL cover: inta_n low with ivect = 8'h08 -> cpu_din = 8'h08 the same cycle, ready 1, slv_sel 0.
REQ-042 The bench SHALL cover: two overlapping regions both matching 0x0060 -> lower index selected.
REQ-043 The bench SHALL cover: reset pulsed during WAIT with rd_n held low -> IDLE next cycle, no new cycle until rd_n goes high then low.
